// File: rtl/ras_ctrl_if.sv
// ras_ctrl_if: bundles the instruction handshake, resolution inputs, the
// ras command/data ports and the prediction outputs of ras_ctrl.
// The slave modport is the ras_ctrl side; master is its environment.
interface ras_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic             in_is_jal;
    logic             in_is_jalr;
    logic             in_is_cbr;
    logic             in_is_rvc;
    logic             resolve_valid;
    logic             resolve_mispredict;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_branch;
    logic             ras_close_valid;
    logic             ras_close_invalid;
    logic [WIDTH-1:0] ras_din;
    logic [WIDTH-1:0] ras_dout;
    logic             pred_valid;
    logic [WIDTH-1:0] pred_target;
    logic [ADDR:0]    depth;

    modport slave (
        input  in_valid, in_pc, in_rd, in_rs1,
        input  in_is_jal, in_is_jalr, in_is_cbr, in_is_rvc,
        input  resolve_valid, resolve_mispredict, ras_dout,
        output in_ready, ras_push, ras_pop, ras_branch,
        output ras_close_valid, ras_close_invalid, ras_din,
        output pred_valid, pred_target, depth
    );

    modport master (
        output in_valid, in_pc, in_rd, in_rs1,
        output in_is_jal, in_is_jalr, in_is_cbr, in_is_rvc,
        output resolve_valid, resolve_mispredict, ras_dout,
        input  in_ready, ras_push, ras_pop, ras_branch,
        input  ras_close_valid, ras_close_invalid, ras_din,
        input  pred_valid, pred_target, depth
    );
endinterface

// File: rtl/ras_ctrl.sv
// ras_ctrl: classifies accepted instructions as call / return / coroutine /
// conditional branch, drives the ras push/pop/branch/close pulses, registers
// the popped ras data as a return prediction and tracks one speculation level.
// Optional feature macro: RAS_CTRL_RVC_EN (compressed calls link to pc+2).
module ras_ctrl #(
    parameter int WIDTH = 32,
    parameter int ADDR  = 10,
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    ras_ctrl_if.slave   bus
);
    typedef enum logic {NORMAL, SPEC} state_t;

    localparam logic [ADDR:0] DEPTH_MAX = (ADDR+1)'(DEPTH);

    state_t           state;
    logic [ADDR:0]    depth_q;
    logic [ADDR:0]    ckpt_q;
    logic             push_q, pop_q, branch_q, close_valid_q, close_invalid_q;
    logic [WIDTH-1:0] din_q;
    logic             pred_valid_q;
    logic [WIDTH-1:0] pred_target_q;

    logic             ready, accept, link_rd, link_rs1;
    logic             is_cbr, is_jal, is_jalr;
    logic             want_push, want_pop, do_pop, resolve_now;
    logic [WIDTH-1:0] ret_addr;

    // Classify the offered instruction and decide this cycle's ras actions
    always_comb begin
        ready       = !rst && !(state == SPEC && (bus.in_is_cbr || bus.resolve_valid));
        accept      = bus.in_valid && ready;
        link_rd     = (bus.in_rd == 5'd1) || (bus.in_rd == 5'd5);
        link_rs1    = (bus.in_rs1 == 5'd1) || (bus.in_rs1 == 5'd5);
        is_cbr      = bus.in_is_cbr;
        is_jal      = bus.in_is_jal && !is_cbr;
        is_jalr     = bus.in_is_jalr && !is_cbr;
        want_push   = accept && link_rd && (is_jal || is_jalr);
        want_pop    = accept && is_jalr && link_rs1 && !(link_rd && bus.in_rd == bus.in_rs1);
        do_pop      = want_pop && (depth_q != '0);
        resolve_now = (state == SPEC) && bus.resolve_valid;
`ifdef RAS_CTRL_RVC_EN
        ret_addr    = bus.in_pc + (bus.in_is_rvc ? WIDTH'(2) : WIDTH'(4));
`else
        ret_addr    = bus.in_pc + WIDTH'(4);
`endif
    end

`ifndef RAS_CTRL_RVC_EN
    logic rvc_unused;
    assign rvc_unused = bus.in_is_rvc;
`endif

    // Speculation FSM, depth tracking, ras pulses and prediction register
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= NORMAL;
            depth_q         <= '0;
            ckpt_q          <= '0;
            push_q          <= 1'b0;
            pop_q           <= 1'b0;
            branch_q        <= 1'b0;
            close_valid_q   <= 1'b0;
            close_invalid_q <= 1'b0;
            din_q           <= '0;
            pred_valid_q    <= 1'b0;
            pred_target_q   <= '0;
        end else begin
            push_q          <= want_push;
            pop_q           <= do_pop;
            branch_q        <= accept && is_cbr && (state == NORMAL);
            close_valid_q   <= resolve_now && !bus.resolve_mispredict;
            close_invalid_q <= resolve_now && bus.resolve_mispredict;
            pred_valid_q    <= pop_q;
            if (want_push) begin
                din_q <= ret_addr;
            end
            if (pop_q) begin
                pred_target_q <= bus.ras_dout;
            end
            if (resolve_now) begin
                state <= NORMAL;
                if (bus.resolve_mispredict) begin
                    depth_q <= ckpt_q;
                end
            end else begin
                if (accept && is_cbr && state == NORMAL) begin
                    state  <= SPEC;
                    ckpt_q <= depth_q;
                end
                if (want_push && !do_pop) begin
                    if (depth_q != DEPTH_MAX) begin
                        depth_q <= depth_q + 1'b1;
                    end
                end else if (do_pop && !want_push) begin
                    depth_q <= depth_q - 1'b1;
                end
            end
        end
    end

    assign bus.in_ready          = ready;
    assign bus.ras_push          = push_q;
    assign bus.ras_pop           = pop_q;
    assign bus.ras_branch        = branch_q;
    assign bus.ras_close_valid   = close_valid_q;
    assign bus.ras_close_invalid = close_invalid_q;
    assign bus.ras_din           = din_q;
    assign bus.pred_valid        = pred_valid_q;
    assign bus.pred_target       = pred_target_q;
    assign bus.depth             = depth_q;
endmodule

// File: tb/tb_ras_ctrl.sv
// tb_ras_ctrl: directed vectors with hand-computed expectations for ras_ctrl
// (small DEPTH so saturation can be reached quickly).
module tb_ras_ctrl;
    localparam int WIDTH = 32;
    localparam int ADDR  = 3;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ras_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    ras_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for a single edge, then withdraw it
    task automatic applyStimulus(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic jal, input logic jalr, input logic cbr, input logic rvc);
        bus.in_valid   = 1'b1;
        bus.in_pc      = pc;
        bus.in_rd      = rd;
        bus.in_rs1     = rs1;
        bus.in_is_jal  = jal;
        bus.in_is_jalr = jalr;
        bus.in_is_cbr  = cbr;
        bus.in_is_rvc  = rvc;
        tick();
        bus.in_valid   = 1'b0;
        bus.in_is_jal  = 1'b0;
        bus.in_is_jalr = 1'b0;
        bus.in_is_cbr  = 1'b0;
        bus.in_is_rvc  = 1'b0;
    endtask

    initial begin
        logic [31:0] rvc_exp;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_pc = '0;
        bus.in_rd = '0;
        bus.in_rs1 = '0;
        bus.in_is_jal = 1'b0;
        bus.in_is_jalr = 1'b0;
        bus.in_is_cbr = 1'b0;
        bus.in_is_rvc = 1'b0;
        bus.resolve_valid = 1'b0;
        bus.resolve_mispredict = 1'b0;
        bus.ras_dout = '0;
        tick();
        tick();

        // reset state
        checkOutput("rst_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_depth", 32'(bus.depth), 32'd0);
        checkOutput("rst_push", 32'(bus.ras_push), 32'd0);
        checkOutput("rst_pred", 32'(bus.pred_valid), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", 32'(bus.in_ready), 32'd1);

        // return on empty stack
        applyStimulus(32'h50, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("empty_pop", 32'(bus.ras_pop), 32'd0);
        checkOutput("empty_depth", 32'(bus.depth), 32'd0);
        tick();
        checkOutput("empty_pred", 32'(bus.pred_valid), 32'd0);

        // call then return
        applyStimulus(32'h100, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("call_push", 32'(bus.ras_push), 32'd1);
        checkOutput("call_din", bus.ras_din, 32'h104);
        checkOutput("call_depth", 32'(bus.depth), 32'd1);
        bus.ras_dout = 32'h104;
        applyStimulus(32'h180, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ret_pop", 32'(bus.ras_pop), 32'd1);
        checkOutput("ret_nopush", 32'(bus.ras_push), 32'd0);
        checkOutput("ret_depth", 32'(bus.depth), 32'd0);
        checkOutput("ret_pred_early", 32'(bus.pred_valid), 32'd0);
        tick();
        checkOutput("ret_pred_valid", 32'(bus.pred_valid), 32'd1);
        checkOutput("ret_pred_target", bus.pred_target, 32'h104);
        checkOutput("ret_pop_once", 32'(bus.ras_pop), 32'd0);
        tick();
        checkOutput("ret_pred_once", 32'(bus.pred_valid), 32'd0);

        // non-link jal does nothing
        applyStimulus(32'h10, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("nolink_push", 32'(bus.ras_push), 32'd0);

        // build depth 2, then coroutine swap
        applyStimulus(32'h10, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h20, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_co_depth", 32'(bus.depth), 32'd2);
        applyStimulus(32'h200, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("co_pop", 32'(bus.ras_pop), 32'd1);
        checkOutput("co_push", 32'(bus.ras_push), 32'd1);
        checkOutput("co_din", bus.ras_din, 32'h204);
        checkOutput("co_depth", 32'(bus.depth), 32'd2);

        // jalr with rd==rs1 link register is push only
        applyStimulus(32'h400, 5'd1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("same_push", 32'(bus.ras_push), 32'd1);
        checkOutput("same_nopop", 32'(bus.ras_pop), 32'd0);
        checkOutput("same_depth", 32'(bus.depth), 32'd3);

        // mispredict: cbr has priority over the jal flag
        applyStimulus(32'h500, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("br_pulse", 32'(bus.ras_branch), 32'd1);
        checkOutput("br_nopush", 32'(bus.ras_push), 32'd0);
        checkOutput("br_depth", 32'(bus.depth), 32'd3);
        applyStimulus(32'h600, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h700, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("spec_depth", 32'(bus.depth), 32'd5);
        bus.resolve_valid = 1'b1;
        bus.resolve_mispredict = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_is_jal = 1'b1;
        bus.in_rd = 5'd1;
        #1;
        checkOutput("resolve_stall", 32'(bus.in_ready), 32'd0);
        tick();
        bus.resolve_valid = 1'b0;
        bus.resolve_mispredict = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_is_jal = 1'b0;
        checkOutput("mis_close_inv", 32'(bus.ras_close_invalid), 32'd1);
        checkOutput("mis_close_val", 32'(bus.ras_close_valid), 32'd0);
        checkOutput("mis_depth", 32'(bus.depth), 32'd3);
        checkOutput("mis_noaccept", 32'(bus.ras_push), 32'd0);

        // branch stall until resolution closes speculation
        applyStimulus(32'h800, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("br2_pulse", 32'(bus.ras_branch), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_is_cbr = 1'b1;
        #1;
        checkOutput("stall_ready", 32'(bus.in_ready), 32'd0);
        tick();
        checkOutput("stall_nobranch", 32'(bus.ras_branch), 32'd0);
        bus.resolve_valid = 1'b1;
        #1;
        checkOutput("stall_ready_res", 32'(bus.in_ready), 32'd0);
        tick();
        bus.resolve_valid = 1'b0;
        #1;
        checkOutput("ok_close_val", 32'(bus.ras_close_valid), 32'd1);
        checkOutput("ok_close_inv", 32'(bus.ras_close_invalid), 32'd0);
        checkOutput("ok_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_is_cbr = 1'b0;
        checkOutput("stalled_br_pulse", 32'(bus.ras_branch), 32'd1);
        checkOutput("ok_depth", 32'(bus.depth), 32'd3);

        // reset in SPEC, then resolution while NORMAL is ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_depth", 32'(bus.depth), 32'd0);
        checkOutput("mid_rst_close", 32'(bus.ras_close_valid), 32'd0);
        bus.resolve_valid = 1'b1;
        bus.resolve_mispredict = 1'b1;
        #1;
        checkOutput("normal_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.resolve_valid = 1'b0;
        bus.resolve_mispredict = 1'b0;
        checkOutput("normal_noclose", 32'(bus.ras_close_invalid), 32'd0);

        // saturation at DEPTH
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(32'h1000 + 32'(i), 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("sat_depth", 32'(bus.depth), 32'(DEPTH));
        checkOutput("sat_push", 32'(bus.ras_push), 32'd1);

        // return address wrap and RVC selection
        applyStimulus(32'hFFFF_FFFE, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_din", bus.ras_din, 32'h2);
`ifdef RAS_CTRL_RVC_EN
        rvc_exp = 32'h302;
`else
        rvc_exp = 32'h304;
`endif
        applyStimulus(32'h300, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("rvc_din", bus.ras_din, rvc_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
